// File: rtl/mac_array_inst_seq.sv
// Instruction sequencer for the systolic MAC array.
// Runs a LOAD -> EXEC -> DRAIN sequence per start pulse and drives the per-row
// 2-bit instructions (bit1 = execute, bit0 = kernel load).
// Two issue modes: skewed, where row r trails row r-1 by one cycle, and
// broadcast, where every row gets the same instruction in the same cycle.
module mac_array_inst_seq #(
    parameter int row    = 8,
    parameter int len_bw = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                data_mode,
    input  logic [len_bw-1:0]   load_len,
    input  logic [len_bw-1:0]   exec_len,
    output logic [2*row-1:0]    inst_row,
    output logic                busy,
    output logic [1:0]          phase,
    output logic                done,
    output logic                start_drop
);

    localparam int DW = $clog2(row + 1);
    localparam logic [len_bw-1:0] CNT_ONE = 1;
    localparam logic [DW-1:0]     DRN_ONE = 1;
    localparam logic [DW-1:0]     DRN_MAX = DW'(row - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [len_bw-1:0]   cnt_q, cnt_d;
    logic [len_bw-1:0]   load_len_q, load_len_d;
    logic [len_bw-1:0]   exec_len_q, exec_len_d;
    logic                mode_q, mode_d;
    logic [DW-1:0]       drn_q, drn_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic                drain_last;
    logic [1:0]          src;
    logic [row-1:0][1:0] inst_q, inst_d;

    // Broadcast needs one drain cycle; skewed needs row cycles so the last
    // execute instruction has shifted out of the final row.
    assign drain_last = mode_q ? (drn_q == '0) : (drn_q == DRN_MAX);

    // Next-state and counter control for the sequence FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drn_d      = drn_q;
        mode_d     = mode_q;
        load_len_d = load_len_q;
        exec_len_d = exec_len_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = data_mode;
                    load_len_d = load_len;
                    exec_len_d = exec_len;
                    cnt_d      = '0;
                    drn_d      = '0;
                    if (load_len != '0)      state_d = LOAD;
                    else if (exec_len != '0) state_d = EXEC;
                    else                     state_d = DRAIN;
                end
            end
            LOAD: begin
                if (cnt_q == load_len_q - CNT_ONE) begin
                    cnt_d   = '0;
                    drn_d   = '0;
                    state_d = (exec_len_q != '0) ? EXEC : DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EXEC: begin
                if (cnt_q == exec_len_q - CNT_ONE) begin
                    cnt_d   = '0;
                    drn_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q + DRN_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start && (state_q != IDLE)) drop_d = 1'b1;
    end

    // Source instruction and next values of the per-row instruction registers.
    always_comb begin
        src    = 2'b00;
        inst_d = '0;
        case (state_q)
            LOAD:    src = 2'b01;
            EXEC:    src = 2'b10;
            default: src = 2'b00;
        endcase
        if (mode_q) begin
            for (int r = 0; r < row; r++) inst_d[r] = src;
        end else begin
            inst_d[0] = src;
            for (int r = 1; r < row; r++) inst_d[r] = inst_q[r-1];
        end
    end

    // FSM state, counters and latched sequence parameters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drn_q      <= '0;
            mode_q     <= 1'b0;
            load_len_q <= '0;
            exec_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drn_q      <= drn_d;
            mode_q     <= mode_d;
            load_len_q <= load_len_d;
            exec_len_q <= exec_len_d;
        end
    end

    // Instruction registers update every cycle, shifting or broadcasting src.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) inst_q <= '0;
        else        inst_q <= inst_d;
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign inst_row   = inst_q;
    assign busy       = (state_q != IDLE);
    assign phase      = state_q;
    assign done       = done_q;
    assign start_drop = drop_q;

endmodule

// File: doc/mac_array_inst_seq.md
Name: mac_array_inst_seq

Overview:
- Parametrised instruction sequencer for the systolic MAC array; replaces the hard-coded 8-row instruction shift chain.
- Runs a kernel-load / execute / drain sequence from a single start pulse, with programmable cycle counts.
- Drives per-row 2-bit instructions in either skewed mode (one cycle per row) or broadcast mode.
- Sits between the top-level controller and the mac_row instances; its inst_row output feeds the rows' inst_w inputs directly.

Parameters:
- row, 8, number of MAC rows; row >= 2.
- len_bw, 16, width of the load-length and execute-length counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- data_mode  in  1  1 = broadcast (all rows same cycle), 0 = skewed; sampled only on an accepted start.
- load_len  in  len_bw  number of kernel-load cycles; sampled on an accepted start.
- exec_len  in  len_bw  number of execute cycles; sampled on an accepted start.
- inst_row  out  2*row  per-row instruction; row r occupies bits [2r+1:2r]; bit1 = execute, bit0 = kernel load.
- busy  out  1  high whenever the state is not IDLE.
- phase  out  2  state encoding: 0 IDLE, 1 LOAD, 2 EXEC, 3 DRAIN.
- done  out  1  one-cycle pulse when a sequence completes.
- start_drop  out  1  one-cycle pulse when start is asserted while busy.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; inst_row=0; busy=0; phase=0; done=0; start_drop=0; counters and latched mode/lengths cleared. Reset mid-sequence aborts immediately; no done pulse.
- Accepted start (start=1 in IDLE): latch data_mode, load_len and exec_len.
- Next state after an accepted start:
  - LOAD if load_len != 0;
  - else EXEC if exec_len != 0;
  - else DRAIN.
- LOAD lasts exactly load_len cycles, then goes to EXEC if exec_len != 0, else to DRAIN.
- EXEC lasts exactly exec_len cycles, then goes to DRAIN.
- DRAIN lasts row cycles in skewed mode, 1 cycle in broadcast mode, then goes to IDLE with done=1 for that first IDLE cycle.
- Source instruction src is combinational from state: LOAD=2'b01, EXEC=2'b10, IDLE/DRAIN=2'b00. LOAD→EXEC is back-to-back, with no bubble.
- Instruction registers, updated every clk edge:
  - Skewed: row0 <= src; row r <= row r-1 for r = 1..row-1. Row r sees src delayed by r+1 cycles.
  - Broadcast: every row <= src, so all rows see src delayed by 1 cycle.
- Guarantee: in the done cycle inst_row == 0 in both modes. Drain length is chosen so that the last execute instruction has left row row-1.
- A start while busy is ignored: state and latched values are unchanged, and start_drop=1 in the following cycle.
- start coinciding with the done cycle (state already IDLE) is accepted normally, giving back-to-back sequences.
- data_mode, load_len and exec_len changes while busy have no effect.
- Counters are len_bw wide, so the maximum length is 2^len_bw - 1 with no wrap. The drain counter is sized to hold row (clog2).
- done and start_drop are registered outputs; busy and phase decode the state register.

Test Plan:
- Reset mid-EXEC in skewed mode (row=8) -> inst_row=0, phase=0, busy=0 asynchronously; no done pulse follows; next start runs cleanly.
- Skewed, load_len=3, exec_len=2, row=8:
  - inst_row[1:0] = 01 for 3 cycles then 10 for 2 cycles, starting the cycle after LOAD entry;
  - inst_row[15:14] shows the same pattern 7 cycles later;
  - done pulses 1+3+2+8 cycles after start; inst_row=0 in the done cycle.
- Broadcast, load_len=2, exec_len=4 -> all 8 row fields equal at every cycle (01,01,10,10,10,10); done 1+2+4+1 cycles after start.
- load_len=0, exec_len=0, skewed -> phase goes straight to DRAIN; inst_row stays 0 throughout; done 1+8 cycles after start.
- start pulsed during EXEC with data_mode toggled -> start_drop=1 next cycle; sequence timing and mode unchanged.
- start asserted in the done cycle with load_len=1, exec_len=1 -> accepted; second sequence instructions follow with no gap; parameter sweep row=2 and row=16 confirms skew of r+1 and drain of row cycles.
